dbgcnt_ctrl: RTL



---
 rtl/dbgcnt_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/dbgcnt_ctrl.sv
// Debug toggle counter controller: per-channel shadow/active config words,
// period-boundary commits, and a run/burst/drain sequencer for the global enable.
`timescale 1ns/1ps
module dbgcnt_ctrl #(
    parameter int NCH     = 4,
    parameter int BURST_W = 16
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic               reg_wr,
    input  logic               reg_rd,
    input  logic [3:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic               reg_rvalid,
    input  logic [NCH-1:0]     ch_toggle_in,
    output logic [NCH*32-1:0]  dbgcnt_out,
    output logic               glbl_en_out,
    output logic               busy,
    output logic               done_irq
);

    // state | meaning
    // IDLE  | counters disabled, waiting for START
    // RUN   | free-running until STOP
    // BURST | counting channel-0 rises up to BURST_LEN
    // DRAIN | enable held until every channel is low, then done pulse
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [3:0] ADDR_CTRL   = 4'd8;
    localparam logic [3:0] ADDR_BLEN   = 4'd9;
    localparam logic [3:0] ADDR_STATUS = 4'd10;
    localparam logic [3:0] ADDR_COMMIT = 4'd11;
    localparam logic [BURST_W-1:0] CNT_ONE = 1;

    state_t               state_q, state_d;
    logic [31:0]          shadow_q [NCH];
    logic [31:0]          shadow_d [NCH];
    logic [31:0]          active_q [NCH];
    logic [31:0]          active_d [NCH];
    logic [NCH-1:0]       pend_q, pend_d;
    logic [BURST_W-1:0]   blen_q, blen_d;
    logic [BURST_W-1:0]   cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic [NCH-1:0]       tog_q, tog_prev_q;
    logic [31:0]          rdata_q, rdata_d;
    logic                 rvalid_q;

    logic                 wr_ctrl, start, stop, wr_commit;
    logic                 rise0;
    logic [NCH-1:0]       fall;
    logic [NCH-1:0]       commit_ev;

    always_comb begin
        wr_ctrl   = reg_wr && (reg_addr == ADDR_CTRL);
        wr_commit = reg_wr && (reg_addr == ADDR_COMMIT);
        start     = wr_ctrl && reg_wdata[0];
        stop      = wr_ctrl && reg_wdata[1];
        rise0     = tog_q[0] && !tog_prev_q[0];
        fall      = ~tog_q & tog_prev_q;
    end

    // Sequencer: enable and done are decoded straight from state so that
    // reset clears them asynchronously.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        glbl_en_out = 1'b0;
        done_irq    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = reg_wdata[2] ? ST_BURST : ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                glbl_en_out = 1'b1;
                if (stop) state_d = ST_DRAIN;
            end
            ST_BURST: begin
                glbl_en_out = 1'b1;
                if (rise0 && (cnt_q != '1)) cnt_d = cnt_q + CNT_ONE;
                if (stop || (cnt_q == blen_q)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (|tog_q) begin
                    glbl_en_out = 1'b1;
                end else begin
                    done_irq = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy = (state_q != ST_IDLE);
    end

    // Commit uses the pre-write shadow; a same-cycle COMMIT write re-arms the bit.
    always_comb begin
        mode_d = mode_q;
        blen_d = blen_q;
        if (wr_ctrl) mode_d = reg_wdata[2];
        if (reg_wr && (reg_addr == ADDR_BLEN)) blen_d = reg_wdata[BURST_W-1:0];
        for (int i = 0; i < NCH; i++) begin
            commit_ev[i] = pend_q[i] && (!glbl_en_out || !active_q[i][15] || fall[i]);
            active_d[i]  = commit_ev[i] ? shadow_q[i] : active_q[i];
            shadow_d[i]  = (reg_wr && (reg_addr == 4'(i))) ? reg_wdata : shadow_q[i];
        end
        pend_d = (pend_q & ~commit_ev) | (wr_commit ? reg_wdata[NCH-1:0] : '0);
    end

    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (reg_addr == 4'(i)) rdata_d = shadow_q[i];
        end
        case (reg_addr)
            ADDR_BLEN:   rdata_d = 32'(blen_q);
            ADDR_STATUS: rdata_d = {16'(cnt_q), 8'(pend_q), 6'b0, state_q};
            default: ;
        endcase
        for (int i = 0; i < NCH; i++) begin
            dbgcnt_out[32*i +: 32] = active_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= ST_IDLE;
            pend_q     <= '0;
            blen_q     <= '0;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            tog_q      <= '0;
            tog_prev_q <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            blen_q     <= blen_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            tog_q      <= ch_toggle_in;
            tog_prev_q <= tog_q;
            rvalid_q   <= reg_rd;
            if (reg_rd) rdata_q <= rdata_d;
            for (int i = 0; i < NCH; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign reg_rdata  = rdata_q;
    assign reg_rvalid = rvalid_q;

endmodule
